// File: rtl/time_set_ctrl.sv
// 12-hour HH:MM timekeeper with debounced mode/up buttons and a set-mode FSM.
// Drives BCD digits, per-digit blanking and a 1 Hz seconds indicator.
module time_set_ctrl #(
  parameter int unsigned TICK_DIV        = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned BLINK_HALF      = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [3:0] bcd0,
  output logic [3:0] bcd1,
  output logic [3:0] bcd2,
  output logic [3:0] bcd3,
  output logic [3:0] blank,
  output logic       sec_pulse,
  output logic       sec_led,
  output logic [1:0] mode
);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_SET_HR  = 2'b01;
  localparam logic [1:0] ST_SET_MIN = 2'b10;

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  // Button vectors: index 0 = mode, index 1 = up.
  logic [1:0]         s1_q, s1_d, s2_q, s2_d, db_q, db_d, press_q, press_d;
  logic [1:0][DW-1:0] dcnt_q, dcnt_d;

  logic [1:0]    mode_q, mode_d;
  logic [5:0]    sec_q, sec_d;
  logic [7:0]    min_q, min_d;
  logic [7:0]    hr_q, hr_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          pulse_q, pulse_d;
  logic          led_q, led_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          blink_q, blink_d;
  logic [3:0]    blank_q, blank_d;

  function automatic logic [7:0] min_inc(input logic [7:0] m);
    if (m[3:0] == 4'd9) begin
      if (m[7:4] == 4'd5) return 8'h00;
      return {m[7:4] + 4'd1, 4'd0};
    end
    return {m[7:4], m[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] hr_inc(input logic [7:0] h);
    if (h == 8'h12) return 8'h01;
    if (h[3:0] == 4'd9) return 8'h10;
    return {h[7:4], h[3:0] + 4'd1};
  endfunction

  always_comb begin
    s1_d    = {btn_up, btn_mode};
    s2_d    = s1_q;
    db_d    = db_q;
    press_d = '0;
    dcnt_d  = '0;
    for (int unsigned i = 0; i < 2; i++) begin
      if (s2_q[i] != db_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          db_d[i]    = s2_q[i];
          press_d[i] = s2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_comb begin
    mode_d  = mode_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    pre_d   = '0;
    pulse_d = 1'b0;

    if (pulse_q) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        min_d = min_inc(min_q);
        if (min_q == 8'h59) hr_d = hr_inc(hr_q);
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    // Mode press wins over a simultaneous up press.
    if (press_q[0]) begin
      case (mode_q)
        ST_RUN: begin
          mode_d = ST_SET_HR;
          sec_d  = '0;
        end
        ST_SET_HR: mode_d = ST_SET_MIN;
        default:   mode_d = ST_RUN;
      endcase
    end else if (press_q[1]) begin
      if (mode_q == ST_SET_HR) hr_d = hr_inc(hr_q);
      else if (mode_q == ST_SET_MIN) min_d = min_inc(min_q);
    end

    // Prescaler only advances while staying in RUN; any other path restarts it at 0.
    if (mode_q == ST_RUN && !press_q[0]) begin
      if (pre_q == PRE_LAST) pulse_d = 1'b1;
      else pre_d = pre_q + PW'(1);
    end

    led_d = (mode_d == ST_RUN) ? (led_q ^ pulse_d) : 1'b0;

    bcnt_d  = '0;
    blink_d = 1'b0;
    if (mode_d != ST_RUN && mode_d == mode_q && !press_q[1]) begin
      if (bcnt_q == BLINK_LAST) begin
        blink_d = ~blink_q;
      end else begin
        bcnt_d  = bcnt_q + BW'(1);
        blink_d = blink_q;
      end
    end

    blank_d[3] = (hr_d[7:4] == 4'd0) | ((mode_d == ST_SET_HR) & blink_d);
    blank_d[2] = (mode_d == ST_SET_HR) & blink_d;
    blank_d[1] = (mode_d == ST_SET_MIN) & blink_d;
    blank_d[0] = (mode_d == ST_SET_MIN) & blink_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      db_q    <= '0;
      dcnt_q  <= '0;
      press_q <= '0;
      mode_q  <= ST_RUN;
      sec_q   <= '0;
      min_q   <= 8'h00;
      hr_q    <= 8'h12;
      pre_q   <= '0;
      pulse_q <= 1'b0;
      led_q   <= 1'b0;
      bcnt_q  <= '0;
      blink_q <= 1'b0;
      blank_q <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      db_q    <= db_d;
      dcnt_q  <= dcnt_d;
      press_q <= press_d;
      mode_q  <= mode_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      pre_q   <= pre_d;
      pulse_q <= pulse_d;
      led_q   <= led_d;
      bcnt_q  <= bcnt_d;
      blink_q <= blink_d;
      blank_q <= blank_d;
    end
  end

  assign bcd0      = min_q[3:0];
  assign bcd1      = min_q[7:4];
  assign bcd2      = hr_q[3:0];
  assign bcd3      = hr_q[7:4];
  assign blank     = blank_q;
  assign sec_pulse = pulse_q;
  assign sec_led   = led_q;
  assign mode      = mode_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Randomised and directed bench for time_set_ctrl against an arithmetic clock model.
module tb_time_set_ctrl;

  localparam int TD = 10;
  localparam int DB = 4;
  localparam int BH = 8;

  logic       clk, rst_n, btn_mode, btn_up;
  logic [3:0] bcd0, bcd1, bcd2, bcd3, blank;
  logic       sec_pulse, sec_led;
  logic [1:0] mode;

  time_set_ctrl #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_up(btn_up),
    .bcd0(bcd0), .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3), .blank(blank),
    .sec_pulse(sec_pulse), .sec_led(sec_led), .mode(mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit cmp_on = 1'b0;

  // Reference model: plain hour/minute/second integers plus elapsed-cycle counters.
  int m_hr, m_min, m_sec, m_mode, m_rc, m_since, nm;
  bit m_pulse, m_led, pm, pu;
  bit [1:0] m_db, m_pp;
  bit [2:0] m_raw [2];
  bit [3:0] m_win [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hr = 12; m_min = 0; m_sec = 0; m_mode = 0; m_rc = 0; m_since = 0;
      m_pulse = 0; m_led = 0; m_db = '0; m_pp = '0;
      for (int i = 0; i < 2; i++) begin m_raw[i] = '0; m_win[i] = '0; end
    end else begin
      pm = m_pp[0]; pu = m_pp[1];
      if (m_pulse) begin
        m_sec = (m_sec + 1) % 60;
        if (m_sec == 0) begin
          m_min = (m_min + 1) % 60;
          if (m_min == 0) m_hr = m_hr % 12 + 1;
        end
      end
      nm = m_mode;
      if (pm) begin
        nm = (m_mode + 1) % 3;
        if (m_mode == 0) m_sec = 0;
      end else if (pu && m_mode == 1) m_hr = m_hr % 12 + 1;
      else if (pu && m_mode == 2) m_min = (m_min + 1) % 60;
      if (nm == 0 && m_mode == 0) m_rc++; else m_rc = 0;
      m_pulse = (nm == 0) && (m_rc > 0) && (m_rc % TD == 0);
      if (nm != 0) m_led = 0; else if (m_pulse) m_led = ~m_led;
      if (nm != m_mode || (pu && !pm)) m_since = 0; else m_since++;
      m_mode = nm;
      m_pp = '0;
      for (int i = 0; i < 2; i++) begin
        m_raw[i] = {m_raw[i][1:0], (i == 0) ? btn_mode : btn_up};
        m_win[i] = {m_win[i][2:0], m_raw[i][2]};
        if (m_win[i] == (m_db[i] ? 4'b0000 : 4'b1111)) begin
          m_db[i] = ~m_db[i];
          m_pp[i] = m_db[i];
        end
      end
    end
  end

  function automatic logic [22:0] model_out();
    bit bl;
    logic [3:0] bk;
    bl = (m_mode != 0) && (((m_since / BH) % 2) == 1);
    bk[3] = (m_hr < 10) || (m_mode == 1 && bl);
    bk[2] = (m_mode == 1 && bl);
    bk[1] = (m_mode == 2 && bl);
    bk[0] = (m_mode == 2 && bl);
    return {4'(m_hr / 10), 4'(m_hr % 10), 4'(m_min / 10), 4'(m_min % 10),
            bk, m_pulse, m_led, 2'(m_mode)};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && cmp_on) begin
        total++;
        if ({bcd3, bcd2, bcd1, bcd0, blank, sec_pulse, sec_led, mode} != model_out()) begin
          bad++;
          $display("FAIL cycle_cmp t=%0t got=%h want=%h (bcd3..0,blank,pulse,led,mode)",
                   $time, {bcd3, bcd2, bcd1, bcd0, blank, sec_pulse, sec_led, mode}, model_out());
        end
      end
    end
  end

  task automatic chk(input string nm_s, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm_s, act, exp_v);
    end
  endtask

  task automatic press(input bit bm, input bit bu, input int hold);
    @(posedge clk); #1;
    btn_mode = bm; btn_up = bu;
    repeat (hold) @(posedge clk);
    #1;
    btn_mode = 1'b0; btn_up = 1'b0;
    repeat (10) @(posedge clk);
  endtask

  task automatic wait_time(input logic [15:0] tgt, input int maxc, input string nm_s);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(posedge clk); #1;
      if ({bcd3, bcd2, bcd1, bcd0} == tgt) begin ok = 1'b1; break; end
    end
    chk(nm_s, int'(ok), 1);
  endtask

  task automatic count_to_pulse(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (sec_pulse) begin n = k; break; end
    end
  endtask

  int n, minsave, pulses;
  bit got;

  initial begin
    rst_n = 1'b0; btn_mode = 1'b0; btn_up = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bcd", int'({bcd3, bcd2, bcd1, bcd0}), 16'h1200);
    chk("rst_blank", int'(blank), 0);
    chk("rst_mode", int'(mode), 0);
    chk("rst_led", int'(sec_led), 0);
    rst_n = 1'b1;
    cmp_on = 1'b1;

    count_to_pulse(n);
    chk("first_pulse_latency", n, 10);
    chk("led_after_pulse1", int'(sec_led), 1);
    count_to_pulse(n);
    chk("pulse_period", n, 10);
    chk("led_after_pulse2", int'(sec_led), 0);

    wait_time(16'h0100, 40000, "reach_0100");
    chk("blank_0100", int'(blank), 4'b1000);

    press(1'b1, 1'b0, 3);
    chk("glitch_no_mode", int'(mode), 0);
    press(1'b1, 1'b0, 8);
    chk("enter_set_hr", int'(mode), 1);
    pulses = 0;
    repeat (30) begin @(posedge clk); #1; if (sec_pulse) pulses++; end
    chk("no_pulse_in_set", pulses, 0);

    for (int k = 0; k < 15 && m_hr != 12; k++) press(1'b0, 1'b1, 8);
    minsave = int'(bcd1) * 10 + int'(bcd0);
    for (int i = 1; i <= 12; i++) begin
      press(1'b0, 1'b1, 8);
      chk("hr_step", int'(bcd3) * 10 + int'(bcd2), i);
    end
    chk("min_untouched_hr", int'(bcd1) * 10 + int'(bcd0), minsave);
    for (int i = 0; i < 9; i++) press(1'b0, 1'b1, 8);
    chk("hr_09", int'({bcd3, bcd2}), 8'h09);

    press(1'b1, 1'b0, 8);
    chk("enter_set_min", int'(mode), 2);
    for (int k = 0; k < 61 && m_min != 59; k++) press(1'b0, 1'b1, 8);
    chk("min_59", int'({bcd1, bcd0}), 8'h59);
    press(1'b0, 1'b1, 8);
    chk("min_wrap_00", int'({bcd1, bcd0}), 8'h00);
    chk("min_wrap_hr_kept", int'({bcd3, bcd2}), 8'h09);
    for (int k = 0; k < 59; k++) press(1'b0, 1'b1, 8);
    press(1'b1, 1'b0, 8);
    chk("back_to_run", int'(mode), 0);
    wait_time(16'h1000, 1000, "reach_1000");
    chk("blank_1000", int'(blank), 0);

    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 8);
    chk("set_min_again", int'(mode), 2);
    minsave = int'({bcd1, bcd0});
    @(posedge clk); #1;
    btn_mode = 1'b1; btn_up = 1'b1;
    got = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (mode == 2'b00) begin got = 1'b1; break; end
    end
    btn_mode = 1'b0; btn_up = 1'b0;
    chk("combo_mode_wins", int'(got), 1);
    count_to_pulse(n);
    chk("pulse_after_set", n, 10);
    chk("combo_min_kept", int'({bcd1, bcd0}), minsave);

    press(1'b1, 1'b0, 8);
    press(1'b1, 1'b0, 8);
    chk("pre_reset_mode", int'(mode), 2);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_bcd", int'({bcd3, bcd2, bcd1, bcd0}), 16'h1200);
    chk("async_blank", int'(blank), 0);
    chk("async_mode", int'(mode), 0);
    chk("async_led", int'(sec_led), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int it = 0; it < 700; it++) begin
      @(posedge clk); #1;
      btn_mode = ($urandom_range(0, 3) == 0);
      btn_up   = ($urandom_range(0, 1) == 0);
      repeat ($urandom_range(1, 10)) @(posedge clk);
      #1;
      btn_mode = 1'b0; btn_up = 1'b0;
      repeat ($urandom_range(0, 14)) @(posedge clk);
    end
    repeat (20) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
